// File: rtl/noc_inject_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : noc_inject_arbiter
// Description : Packet-level round-robin arbiter sharing one router injection
//               port between N_REQ local flit sources. A grant is taken on a
//               HEAD/HEADTAIL flit and held until the packet's TAIL, so packets
//               never interleave. The VC is chosen once per packet (lowest
//               enabled VC) and stamped on every flit of that packet.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk_router            router clock
//   rst_router_n          asynchronous active-low reset
//   req_valid[N_REQ]      per-requester flit valid
//   req_flit[N_REQ]       per-requester flit (incoming vc_id is ignored)
//   req_ready[N_REQ]      per-requester accept (combinational)
//   router_data_in        registered flit to router, vc_id overwritten
//   router_valid_in       registered flit valid to router
//   router_is_on_off_out  per-VC on/off from router (1 = may send)
//   grant_idx             requester currently / last locked
//   busy                  packet in progress
//   pkt_cnt               completed packets (wrapping)
//   err_clr               clears the sticky error flags
//   err_orphan            sticky: BODY/TAIL seen outside a packet
//   err_nested            sticky: HEAD/HEADTAIL seen inside a packet
//   stall_err             sticky: locked packet stalled STALL_MAX cycles
//
// Flit layout (MSB..LSB): label[1:0] | vc_id[VCW-1:0] | payload[DATA_W-1:0]
//   label: 0 = BODY, 1 = HEAD, 2 = TAIL, 3 = HEADTAIL
//==============================================================================
module noc_inject_arbiter #(
  parameter  int N_REQ     = 4,
  parameter  int STALL_MAX = 1024,
  parameter  int VC_NUM    = 2,
  parameter  int DATA_W    = 32,
  localparam int IW        = (N_REQ  > 1) ? $clog2(N_REQ)  : 1,
  localparam int VCW       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  localparam int FLIT_W    = 2 + VCW + DATA_W
) (
  input  logic                          clk_router,
  input  logic                          rst_router_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0][FLIT_W-1:0]  req_flit,
  output logic [N_REQ-1:0]              req_ready,
  output logic [FLIT_W-1:0]             router_data_in,
  output logic                          router_valid_in,
  input  logic [VC_NUM-1:0]             router_is_on_off_out,
  output logic [IW-1:0]                 grant_idx,
  output logic                          busy,
  output logic [15:0]                   pkt_cnt,
  input  logic                          err_clr,
  output logic                          err_orphan,
  output logic                          err_nested,
  output logic                          stall_err
);

  typedef struct packed {
    logic [1:0]        label;
    logic [VCW-1:0]    vc_id;
    logic [DATA_W-1:0] payload;
  } flit_t;

  localparam logic [1:0] LBL_BODY     = 2'd0;
  localparam logic [1:0] LBL_HEAD     = 2'd1;
  localparam logic [1:0] LBL_TAIL     = 2'd2;
  localparam logic [1:0] LBL_HEADTAIL = 2'd3;

  localparam logic [15:0] STALL_LIM = 16'(STALL_MAX);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  function automatic logic [1:0] label_of(input logic [FLIT_W-1:0] f);
    flit_t t;
    t = flit_t'(f);
    return t.label;
  endfunction

  function automatic logic is_head(input logic [FLIT_W-1:0] f);
    return (label_of(f) == LBL_HEAD) || (label_of(f) == LBL_HEADTAIL);
  endfunction

  function automatic logic [FLIT_W-1:0] stamp_vc(input logic [FLIT_W-1:0] f,
                                                 input logic [VCW-1:0]    vc);
    flit_t t;
    t       = flit_t'(f);
    t.vc_id = vc;
    return t;
  endfunction

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  state_t              state_q,     state_d;
  logic [IW-1:0]       rr_ptr_q,    rr_ptr_d;
  logic [IW-1:0]       lock_idx_q,  lock_idx_d;
  logic [VCW-1:0]      lock_vc_q,   lock_vc_d;
  logic [15:0]         stall_cnt_q, stall_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [FLIT_W-1:0]   out_data_q,  out_data_d;
  logic [15:0]         pkt_cnt_q,   pkt_cnt_d;
  logic                orphan_q,    orphan_d;
  logic                nested_q,    nested_d;
  logic                stall_err_q, stall_err_d;

  logic [N_REQ-1:0]    ready;
  logic                grant_found;
  logic [IW-1:0]       grant_sel;
  logic [VCW-1:0]      vc_sel;
  logic                orphan_set;
  logic                nested_set;
  logic                stall_set;

  always_comb begin : p_next
    int idx;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_idx_d  = lock_idx_q;
    lock_vc_d   = lock_vc_q;
    stall_cnt_d = '0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    pkt_cnt_d   = pkt_cnt_q;
    ready       = '0;
    grant_found = 1'b0;
    grant_sel   = '0;
    vc_sel      = '0;
    orphan_set  = 1'b0;
    nested_set  = 1'b0;
    stall_set   = 1'b0;
    idx         = 0;

    // Lowest enabled VC wins: scan downwards so the last hit is the lowest.
    for (int v = VC_NUM - 1; v >= 0; v--) begin
      if (router_is_on_off_out[v]) vc_sel = VCW'(v);
    end

    // Round-robin search for a packet start, beginning at rr_ptr.
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_found && req_valid[IW'(idx)] && is_head(req_flit[IW'(idx)])) begin
        grant_found = 1'b1;
        grant_sel   = IW'(idx);
      end
    end

    if (state_q == ST_IDLE) begin
      // Stray BODY/TAIL flits are drained so they cannot block a source,
      // even while another requester is being granted this cycle.
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && !is_head(req_flit[i])) ready[i] = 1'b1;
      end
      orphan_set = |(req_valid & ready);

      if (grant_found && (|router_is_on_off_out)) begin
        ready[grant_sel] = 1'b1;
        out_valid_d      = 1'b1;
        out_data_d       = stamp_vc(req_flit[grant_sel], vc_sel);
        if (label_of(req_flit[grant_sel]) == LBL_HEADTAIL) begin
          rr_ptr_d  = rr_next(grant_sel);
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end else begin
          state_d    = ST_LOCKED;
          lock_idx_d = grant_sel;
          lock_vc_d  = vc_sel;
        end
      end
    end else begin
      // The packet stays on its VC; backpressure on that VC stalls it.
      ready[lock_idx_q] = router_is_on_off_out[lock_vc_q];
      if (req_valid[lock_idx_q] && router_is_on_off_out[lock_vc_q]) begin
        case (label_of(req_flit[lock_idx_q]))
          LBL_BODY: begin
            out_valid_d = 1'b1;
            out_data_d  = stamp_vc(req_flit[lock_idx_q], lock_vc_q);
          end
          LBL_TAIL: begin
            out_valid_d = 1'b1;
            out_data_d  = stamp_vc(req_flit[lock_idx_q], lock_vc_q);
            state_d     = ST_IDLE;
            rr_ptr_d    = rr_next(lock_idx_q);
            pkt_cnt_d   = pkt_cnt_q + 16'd1;
          end
          default: nested_set = 1'b1;
        endcase
      end else begin
        stall_cnt_d = (stall_cnt_q >= STALL_LIM) ? stall_cnt_q : stall_cnt_q + 16'd1;
        stall_set   = (stall_cnt_d >= STALL_LIM);
      end
    end

    // A new error event in the same cycle as a clear keeps the flag set.
    orphan_d    = (orphan_q    & ~err_clr) | orphan_set;
    nested_d    = (nested_q    & ~err_clr) | nested_set;
    stall_err_d = (stall_err_q & ~err_clr) | stall_set;
  end

  always_ff @(posedge clk_router or negedge rst_router_n) begin
    if (!rst_router_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      lock_idx_q  <= '0;
      lock_vc_q   <= '0;
      stall_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      pkt_cnt_q   <= '0;
      orphan_q    <= 1'b0;
      nested_q    <= 1'b0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_idx_q  <= lock_idx_d;
      lock_vc_q   <= lock_vc_d;
      stall_cnt_q <= stall_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      pkt_cnt_q   <= pkt_cnt_d;
      orphan_q    <= orphan_d;
      nested_q    <= nested_d;
      stall_err_q <= stall_err_d;
    end
  end

  // No source may see an accept while the block is held in reset.
  assign req_ready       = rst_router_n ? ready : '0;
  assign router_data_in  = out_data_q;
  assign router_valid_in = out_valid_q;
  assign grant_idx       = lock_idx_q;
  assign busy            = (state_q == ST_LOCKED);
  assign pkt_cnt         = pkt_cnt_q;
  assign err_orphan      = orphan_q;
  assign err_nested      = nested_q;
  assign stall_err       = stall_err_q;

endmodule
`default_nettype wire

// File: tb/tb_noc_inject_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module      : tb_noc_inject_arbiter
// Description : Directed self-checking bench for noc_inject_arbiter with a
//               transaction-level reference model and per-requester flit
//               queues acting as packetizers.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_noc_inject_arbiter;

  localparam int N   = 4;
  localparam int SM  = 8;
  localparam int VCN = 2;
  localparam int DW  = 16;
  localparam int VCW = 1;
  localparam int FW  = 2 + VCW + DW;

  localparam logic [1:0] L_BODY = 2'd0;
  localparam logic [1:0] L_HEAD = 2'd1;
  localparam logic [1:0] L_TAIL = 2'd2;
  localparam logic [1:0] L_HT   = 2'd3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [N-1:0]           req_valid;
  logic [N-1:0][FW-1:0]   req_flit;
  logic [N-1:0]           req_ready;
  logic [FW-1:0]          router_data_in;
  logic                   router_valid_in;
  logic [VCN-1:0]         on_off;
  logic [1:0]             grant_idx;
  logic                   busy;
  logic [15:0]            pkt_cnt;
  logic                   err_clr;
  logic                   err_orphan, err_nested, stall_err;

  noc_inject_arbiter #(
    .N_REQ(N), .STALL_MAX(SM), .VC_NUM(VCN), .DATA_W(DW)
  ) dut (
    .clk_router           (clk),
    .rst_router_n         (rst_n),
    .req_valid            (req_valid),
    .req_flit             (req_flit),
    .req_ready            (req_ready),
    .router_data_in       (router_data_in),
    .router_valid_in      (router_valid_in),
    .router_is_on_off_out (on_off),
    .grant_idx            (grant_idx),
    .busy                 (busy),
    .pkt_cnt              (pkt_cnt),
    .err_clr              (err_clr),
    .err_orphan           (err_orphan),
    .err_nested           (err_nested),
    .stall_err            (stall_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-requester packetizer queues; head of queue is what the source presents.
  logic [FW-1:0] srcq [N][$];
  logic [N-1:0]  acc = '0;
  int            glog [$];   // order of packet-start grants, from the model

  // Sources always carry vc_id=1 so overwriting to VC 0 is observable.
  function automatic logic [FW-1:0] mk(input logic [1:0] l, input logic [DW-1:0] p);
    return {l, 1'b1, p};
  endfunction

  function automatic logic [1:0] lbl(input logic [FW-1:0] f);
    return f[FW-1 -: 2];
  endfunction

  task automatic push(input int i, input logic [1:0] l, input logic [DW-1:0] p);
    srcq[i].push_back(mk(l, p));
  endtask

  // ---------------- reference model (transaction level) ----------------
  int            m_owner;   // -1 = no packet in progress
  int            m_rr, m_vc, m_grant, m_pkt, m_stall;
  logic          m_rv;
  logic [FW-1:0] m_rd;
  logic          m_orphan, m_nested, m_serr;

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_vc = 0; m_grant = 0; m_pkt = 0; m_stall = 0;
    m_rv = 1'b0; m_rd = '0; m_orphan = 1'b0; m_nested = 1'b0; m_serr = 1'b0;
  endtask

  function automatic logic [FW-1:0] with_vc(input logic [FW-1:0] f, input int vc);
    logic [FW-1:0] r;
    r = f;
    r[DW] = vc[0];
    return r;
  endfunction

  task automatic model_step(input logic [N-1:0] er, input int g, input int vc);
    logic os, ns, ss;
    logic [FW-1:0] f;
    os = 1'b0; ns = 1'b0; ss = 1'b0;
    m_rv = 1'b0;
    if (m_owner < 0) begin
      for (int i = 0; i < N; i++)
        if (er[i] && req_valid[i] && i != g) os = 1'b1;
      if (g >= 0) begin
        glog.push_back(g);
        m_rv = 1'b1;
        m_rd = with_vc(req_flit[g], vc);
        if (lbl(req_flit[g]) == L_HT) begin
          m_pkt = (m_pkt + 1) % 65536;
          m_rr  = (g + 1) % N;
        end else begin
          m_owner = g; m_vc = vc; m_grant = g; m_stall = 0;
        end
      end
    end else if (er[m_owner] && req_valid[m_owner]) begin
      m_stall = 0;
      f = req_flit[m_owner];
      if (lbl(f) == L_HEAD || lbl(f) == L_HT) begin
        ns = 1'b1;
      end else begin
        m_rv = 1'b1;
        m_rd = with_vc(f, m_vc);
        if (lbl(f) == L_TAIL) begin
          m_pkt   = (m_pkt + 1) % 65536;
          m_rr    = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end else begin
      m_stall++;
      if (m_stall >= SM) ss = 1'b1;
    end
    m_orphan = (m_orphan & ~err_clr) | os;
    m_nested = (m_nested & ~err_clr) | ns;
    m_serr   = (m_serr   & ~err_clr) | ss;
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin : p_cmp
    logic [N-1:0] er;
    int g, vc, i;
    if (!rst_n) model_reset();
    er = '0; g = -1; vc = -1;
    if (rst_n) begin
      if (m_owner < 0) begin
        for (int v = 0; v < VCN; v++) if (vc < 0 && on_off[v]) vc = v;
        if (vc >= 0) begin
          for (int k = 0; k < N; k++) begin
            i = (m_rr + k) % N;
            if (g < 0 && req_valid[i] && (lbl(req_flit[i]) == L_HEAD || lbl(req_flit[i]) == L_HT))
              g = i;
          end
        end
        for (int j = 0; j < N; j++)
          if (req_valid[j] && (lbl(req_flit[j]) == L_BODY || lbl(req_flit[j]) == L_TAIL)) er[j] = 1'b1;
        if (g >= 0) er[g] = 1'b1;
      end else begin
        er[m_owner] = on_off[m_vc];
      end
    end
    chk("req_ready",       32'(req_ready),       32'(er));
    chk("router_valid_in", 32'(router_valid_in), 32'(m_rv));
    chk("router_data_in",  32'(router_data_in),  32'(m_rd));
    chk("busy",            32'(busy),            32'(m_owner >= 0));
    chk("grant_idx",       32'(grant_idx),       32'(m_grant));
    chk("pkt_cnt",         32'(pkt_cnt),         32'(m_pkt));
    chk("err_orphan",      32'(err_orphan),      32'(m_orphan));
    chk("err_nested",      32'(err_nested),      32'(m_nested));
    chk("stall_err",       32'(stall_err),       32'(m_serr));
    acc = req_valid & req_ready;
    if (rst_n) model_step(er, g, vc);
  end

  // ---------------- source driver ----------------
  initial begin : p_drive
    req_valid = '0;
    req_flit  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        req_valid[i] = (srcq[i].size() > 0);
        req_flit[i]  = (srcq[i].size() > 0) ? srcq[i][0] : '0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin : p_watchdog
    #100000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: bench did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin : p_main
    rst_n = 1'b0; on_off = 2'b11; err_clr = 1'b0;
    tick(3);
    chk("reset busy",     32'(busy), 32'd0);
    chk("reset valid",    32'(router_valid_in), 32'd0);
    chk("reset data",     32'(router_data_in), 32'd0);
    chk("reset pkt_cnt",  32'(pkt_cnt), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Fairness: every requester holds two HEADTAILs.
    glog.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, L_HT, 16'(16'h100 + 16 * r + i));
    tick(12);
    chk("fair grants", 32'(glog.size()), 32'd8);
    if (glog.size() >= 5) begin
      chk("fair g0", 32'(glog[0]), 32'd0);
      chk("fair g1", 32'(glog[1]), 32'd1);
      chk("fair g2", 32'(glog[2]), 32'd2);
      chk("fair g3", 32'(glog[3]), 32'd3);
      chk("fair g4", 32'(glog[4]), 32'd0);
    end
    chk("fair pkt_cnt", 32'(pkt_cnt), 32'd8);

    // Single HEADTAIL on req0: VC 0 stamped over the source's vc_id=1.
    glog.delete();
    push(0, L_HT, 16'hA5A5);
    tick(3);
    chk("single data",    32'(router_data_in), 32'h6A5A5);
    chk("single pkt_cnt", 32'(pkt_cnt), 32'd9);

    // Packet lock: req1 4-flit packet while req2 waits with a HEADTAIL.
    glog.delete();
    push(1, L_HEAD, 16'h11); push(1, L_BODY, 16'h12);
    push(1, L_BODY, 16'h13); push(1, L_TAIL, 16'h14);
    push(2, L_HT,   16'h21);
    tick(8);
    chk("lock grants", 32'(glog.size()), 32'd2);
    if (glog.size() >= 2) begin
      chk("lock first",  32'(glog[0]), 32'd1);
      chk("lock second", 32'(glog[1]), 32'd2);
    end
    chk("lock last data", 32'(router_data_in), 32'h60021);
    chk("lock pkt_cnt",   32'(pkt_cnt), 32'd11);

    // VC choice and backpressure: only VC1 on at HEAD, then VC1 drops.
    on_off = 2'b10;
    push(0, L_HEAD, 16'h31); push(0, L_BODY, 16'h32);
    push(0, L_BODY, 16'h33); push(0, L_TAIL, 16'h34);
    tick(2);
    chk("vc head busy", 32'(busy), 32'd1);
    chk("vc head data", 32'(router_data_in), 32'h30031);
    on_off = 2'b01;
    tick(3);
    chk("vc stalled busy", 32'(busy), 32'd1);
    on_off = 2'b10;
    tick(6);
    chk("vc tail data", 32'(router_data_in), 32'h50034);
    chk("vc pkt_cnt",   32'(pkt_cnt), 32'd12);

    // Orphan TAIL in IDLE is drained and flagged, not forwarded.
    push(3, L_TAIL, 16'h77);
    tick(3);
    chk("orphan flag", 32'(err_orphan), 32'd1);
    chk("orphan data", 32'(router_data_in), 32'h50034);

    // Nested HEAD inside a packet.
    on_off = 2'b11;
    push(2, L_HEAD, 16'h41); push(2, L_HEAD, 16'h42); push(2, L_TAIL, 16'h43);
    tick(6);
    chk("nested flag", 32'(err_nested), 32'd1);
    chk("nested data", 32'(router_data_in), 32'h40043);
    chk("nested pkt",  32'(pkt_cnt), 32'd13);

    // Stall: locked with nothing offered; flag appears on the 8th idle cycle.
    push(1, L_HEAD, 16'h51);
    tick(2);
    tick(7);
    chk("stall early", 32'(stall_err), 32'd0);
    tick(1);
    chk("stall set",   32'(stall_err), 32'd1);
    chk("stall busy",  32'(busy), 32'd1);
    push(1, L_TAIL, 16'h52);
    tick(3);
    chk("stall done busy", 32'(busy), 32'd0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("clr orphan", 32'(err_orphan), 32'd0);
    chk("clr nested", 32'(err_nested), 32'd0);
    chk("clr stall",  32'(stall_err),  32'd0);

    // Reset in the middle of a packet.
    push(0, L_HEAD, 16'h61);
    tick(2);
    chk("pre-reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst busy",  32'(busy), 32'd0);
    chk("rst valid", 32'(router_valid_in), 32'd0);
    chk("rst pkt",   32'(pkt_cnt), 32'd0);
    chk("rst ready", 32'(req_ready), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    push(0, L_BODY, 16'h62);
    tick(3);
    chk("post-rst orphan", 32'(err_orphan), 32'd1);
    chk("post-rst valid",  32'(router_valid_in), 32'd0);
    chk("post-rst busy",   32'(busy), 32'd0);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/noc_inject_arbiter.md
Name: noc_inject_arbiter

Overview:
Packet-level round-robin arbiter that shares one router injection port between N_REQ local flit sources (DLA-side packetizers). It grants on a HEAD/HEADTAIL flit and holds the grant until the packet ends, so flits from different packets never interleave. At packet start it picks a VC from the router's per-VC on/off status and stamps that VC on every flit of the packet. It sits between the per-DLA packetizers and the router local input port.

Parameters:
N_REQ, 4, number of requesters (2..8); index width IW = $clog2(N_REQ)
STALL_MAX, 1024, cycles without a transfer while locked before stall_err is raised (1..65535)

Ports:
clk_router  in  1  router clock
rst_router_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester flit valid
req_flit  in  N_REQ x $bits(flit_t)  per-requester flit; vc_id field ignored
req_ready  out  N_REQ  per-requester accept (combinational)
router_data_in  out  $bits(flit_t)  flit to router, vc_id overwritten
router_valid_in  out  1  flit valid to router
router_is_on_off_out  in  VC_NUM  router per-VC on/off (1 = may send)
grant_idx  out  IW  requester currently locked
busy  out  1  packet in progress (state LOCKED)
pkt_cnt  out  16  completed packets, wraps at 0xFFFF -> 0
err_clr  in  1  clears sticky errors
err_orphan  out  1  sticky: BODY/TAIL received outside a packet
err_nested  out  1  sticky: HEAD/HEADTAIL received inside a packet
stall_err  out  1  sticky: lock stalled for STALL_MAX cycles

Behaviour:
- Reset (async, rst_router_n=0): state IDLE, rr_ptr=0, lock_idx=0, lock_vc=0, stall_cnt=0. Outputs router_valid_in=0, router_data_in=0, grant_idx=0, busy=0, pkt_cnt=0, all errors 0. req_ready=0 while in reset. A reset mid-packet drops the packet immediately. No flit is emitted after reset release until a new HEAD arrives.
- Transfer on requester i = req_valid[i] & req_ready[i]. A transferred flit appears on router_data_in with router_valid_in=1 exactly one cycle later (registered). Otherwise router_valid_in=0 and data holds.
- IDLE:
  - Eligible requester: req_valid=1 with label HEAD or HEADTAIL.
  - If any requester is eligible and |router_is_on_off_out: g = first eligible index scanning rr_ptr, rr_ptr+1 ... mod N_REQ. vc = lowest set bit of router_is_on_off_out. req_ready[g]=1 and the flit is forwarded with vc_id=vc.
  - HEADTAIL: stay IDLE, rr_ptr <= (g+1) mod N_REQ, pkt_cnt++.
  - HEAD: go to LOCKED, lock_idx<=g, lock_vc<=vc, grant_idx<=g.
  - Requesters presenting BODY/TAIL in IDLE get req_ready=1, the flit is discarded (not forwarded), and err_orphan is set. This applies in the same cycle as a grant to another requester.
  - If all VCs are off: no grant, and only orphan flits are drained.
- LOCKED (busy=1):
  - req_ready[lock_idx] = router_is_on_off_out[lock_vc]; all other req_ready=0.
  - BODY transfer: forward with vc_id=lock_vc.
  - TAIL transfer: forward, go to IDLE, rr_ptr <= (lock_idx+1) mod N_REQ, pkt_cnt++.
  - HEAD/HEADTAIL from lock_idx: accepted, discarded, err_nested set, stay LOCKED.
  - lock_vc does not change during a packet even if another VC turns on.
- stall_cnt (16b) counts LOCKED cycles without a transfer and resets to 0 on any transfer or on leaving LOCKED. When it reaches STALL_MAX, stall_err is set. The counter saturates, and the packet is not aborted.
- Sticky errors clear on err_clr=1. If set and clear occur in the same cycle, set wins.
- grant_idx holds its last value in IDLE.

Test Plan:
- Single HEADTAIL: req0 HEADTAIL, on_off=2'b11 -> req_ready[0]=1 that cycle; next cycle router_valid_in=1 with vc_id=0; pkt_cnt=1, rr_ptr=1.
- Fairness: all 4 requesters hold HEADTAIL continuously -> grants run 0,1,2,3,0 on consecutive cycles; pkt_cnt=5 after 5 cycles.
- Packet lock: req1 sends HEAD,BODY,BODY,TAIL while req2 holds a HEAD -> req2 is not granted until the cycle after req1's TAIL; all 4 router flits carry the same vc_id.
- VC choice and backpressure: on_off=2'b10 at HEAD -> vc_id=1; drop on_off[1] mid-packet for 3 cycles -> req_ready=0 and router_valid_in=0 for 3 cycles, then the packet resumes on vc 1.
- Errors: TAIL on req3 in IDLE -> dropped, err_orphan=1. HEAD within a locked packet -> err_nested=1. STALL_MAX=8 with req_valid=0 while locked -> stall_err=1 after 8 cycles. err_clr -> all errors 0.
- Reset mid-packet: assert rst_router_n=0 after HEAD -> router_valid_in=0, busy=0, pkt_cnt=0 immediately; after release, BODY on req0 -> err_orphan=1.
